discrete_range_scheduler: RTL



---
 rtl/discrete_range_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/discrete_range_scheduler.sv
// Sequencer for the discrete-range randomizer: walks each variable, reduces a random word modulo its size.
// Optional abort port pair (in_abort/out_aborted) is enabled by defining DISCRETE_SCHEDULER_ABORT_EN.
module discrete_range_scheduler #(
    parameter int unsigned NUM_VARS  = 4,
    parameter int unsigned VAR_IDX_W = 2,
    parameter int unsigned SIZE_W    = 2,
    parameter int unsigned RAND_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_start,
    output logic [VAR_IDX_W-1:0] out_size_query_index,
    input  logic [SIZE_W-1:0]    in_size,
    input  logic [RAND_W-1:0]    in_random,
    output logic                 out_valid,
    input  logic                 in_ready,
    output logic [VAR_IDX_W-1:0] out_variable_index,
    output logic [SIZE_W-1:0]    out_value_index,
    output logic                 out_busy,
    output logic                 out_done
`ifdef DISCRETE_SCHEDULER_ABORT_EN
    ,
    input  logic                 in_abort,
    output logic                 out_aborted
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CAPTURE,
        S_REDUCE,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_e;

    localparam logic [VAR_IDX_W-1:0] LAST_VAR = VAR_IDX_W'(NUM_VARS - 1);

    state_e                 state_q, state_d;
    logic [VAR_IDX_W-1:0]   var_q, var_d;
    logic [SIZE_W-1:0]      size_q, size_d;
    logic [RAND_W-1:0]      rem_q, rem_d;
    logic                   valid_q, valid_d;
    logic [VAR_IDX_W-1:0]   vidx_q, vidx_d;
    logic [SIZE_W-1:0]      val_q, val_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef DISCRETE_SCHEDULER_ABORT_EN
    logic                   aborted_q, aborted_d;
`endif

    // Next-state and registered-output computation; outputs track the state being entered.
    always_comb begin
        state_d = state_q;
        var_d   = var_q;
        size_d  = size_q;
        rem_d   = rem_q;
        vidx_d  = vidx_q;
        val_d   = val_q;
`ifdef DISCRETE_SCHEDULER_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    var_d   = '0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CAPTURE;
            S_CAPTURE: begin
                size_d  = in_size;
                rem_d   = in_random;
                state_d = (in_size == '0) ? S_NEXT : S_REDUCE;
            end
            S_REDUCE: begin
                // Repeated subtraction: size is zero-extended so rem never underflows.
                if (rem_q >= RAND_W'(size_q)) begin
                    rem_d = rem_q - RAND_W'(size_q);
                end else begin
                    vidx_d  = var_q;
                    val_d   = rem_q[SIZE_W-1:0];
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (valid_q && in_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (var_q == LAST_VAR) begin
                    state_d = S_DONE;
                end else begin
                    var_d   = var_q + VAR_IDX_W'(1);
                    state_d = S_LOOKUP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef DISCRETE_SCHEDULER_ABORT_EN
        // Abort wins over any concurrent handshake.
        if (in_abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end
`endif
        valid_d = (state_d == S_EMIT);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            var_q     <= '0;
            size_q    <= '0;
            rem_q     <= '0;
            valid_q   <= 1'b0;
            vidx_q    <= '0;
            val_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DISCRETE_SCHEDULER_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            var_q     <= var_d;
            size_q    <= size_d;
            rem_q     <= rem_d;
            valid_q   <= valid_d;
            vidx_q    <= vidx_d;
            val_q     <= val_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef DISCRETE_SCHEDULER_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign out_size_query_index = var_q;
    assign out_valid            = valid_q;
    assign out_variable_index   = vidx_q;
    assign out_value_index      = val_q;
    assign out_busy             = busy_q;
    assign out_done             = done_q;
`ifdef DISCRETE_SCHEDULER_ABORT_EN
    assign out_aborted          = aborted_q;
`endif

endmodule
